dsp_sequencer: RTL and testbench

Per-frame instruction sequencer for the DSP core. On each sample-rate strobe it streams a program of up to 2^PROG_ADDR_WIDTH instruction words from a synchronous program RAM into the core's instruction port, one word per clock. It then issues NOPs until the core pipeline has fully drained and signals frame completion. It also detects and flags sample-rate overruns and counts completed frames for the control CPU.

---
 rtl/dsp_sequencer_if.sv | 24 ++
 rtl/dsp_sequencer.sv | 158 +++++++++++++++
 tb/tb_dsp_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_sequencer_if.sv
// Program RAM read bus between the DSP sequencer and its synchronous program store.
`timescale 1ns/1ps
interface dsp_sequencer_if #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10
);
  logic                       prog_rd_en;
  logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr;
  logic [INSTR_WIDTH-1:0]     prog_rd_data;

  // Sequencer side: drives the read request, receives the word one cycle later.
  modport master (
    output prog_rd_en,
    output prog_rd_addr,
    input  prog_rd_data
  );

  // Program RAM side.
  modport slave (
    input  prog_rd_en,
    input  prog_rd_addr,
    output prog_rd_data
  );
endinterface

// File: rtl/dsp_sequencer.sv
// Per-frame DSP instruction sequencer: on an accepted sample strobe it streams
// the program from RAM into the core, pads with NOPs until the pipeline drains,
// pulses frame_done, counts frames and flags strobes that arrive mid-frame.
`timescale 1ns/1ps
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPE_DEPTH      = 5,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run_en,
  input  logic                       sample_strobe,
  input  logic [PROG_ADDR_WIDTH:0]   prog_len,
  dsp_sequencer_if.master            prog,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clear,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  // The drain counter runs 0..PIPE_DEPTH, covering the last RAM read, the
  // issue register and PIPE_DEPTH trailing NOP cycles.
  localparam int DRAIN_CNT_WIDTH = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(PIPE_DEPTH);
  localparam logic [PROG_ADDR_WIDTH:0]   MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_r;
  logic                        rd_en_r;
  logic [PROG_ADDR_WIDTH-1:0]  rd_addr_r;
  logic [PROG_ADDR_WIDTH-1:0]  last_addr_r;
  logic [DRAIN_CNT_WIDTH-1:0]  drain_cnt_r;
  logic                        valid_d_r;
  logic [INSTR_WIDTH-1:0]      instruction_r;
  logic                        busy_r;
  logic                        frame_done_r;
  logic                        overrun_r;
  logic [FRAME_CNT_WIDTH-1:0]  frame_count_r;

  logic                        strobe_s;
  logic                        accept_s;
  logic                        overrun_set_s;
  logic                        len_zero_s;
  logic [PROG_ADDR_WIDTH-1:0]  last_addr_s;

  // Strobe qualification and clamped program length decode.
  always_comb begin
    strobe_s      = sample_strobe & run_en;
    accept_s      = strobe_s & ((state_r == ST_IDLE) || (state_r == ST_DONE));
    overrun_set_s = strobe_s & busy_r;
    len_zero_s    = (prog_len == {(PROG_ADDR_WIDTH+1){1'b0}});
    // Lengths above the RAM depth clamp to the full RAM; the address never wraps.
    last_addr_s   = (prog_len >= MAX_LEN) ? {PROG_ADDR_WIDTH{1'b1}}
                                          : (prog_len[PROG_ADDR_WIDTH-1:0] - PROG_ADDR_WIDTH'(1));
  end

  // Sequencer FSM with registered RAM request, issue path, status and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      rd_en_r       <= 1'b0;
      rd_addr_r     <= {PROG_ADDR_WIDTH{1'b0}};
      last_addr_r   <= {PROG_ADDR_WIDTH{1'b0}};
      drain_cnt_r   <= {DRAIN_CNT_WIDTH{1'b0}};
      valid_d_r     <= 1'b0;
      instruction_r <= {INSTR_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      overrun_r     <= 1'b0;
      frame_count_r <= {FRAME_CNT_WIDTH{1'b0}};
    end else begin
      frame_done_r  <= 1'b0;
      // RAM data lags the request by one cycle; the valid delay tracks it.
      valid_d_r     <= rd_en_r;
      instruction_r <= valid_d_r ? prog.prog_rd_data : {INSTR_WIDTH{1'b0}};

      // Sticky overrun: a new overrun strobe beats a coincident clear.
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clear) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            busy_r      <= 1'b1;
            rd_addr_r   <= {PROG_ADDR_WIDTH{1'b0}};
            last_addr_r <= last_addr_s;
            if (len_zero_s) begin
              // Empty program: hold busy for one cycle, then report completion.
              state_r     <= ST_DRAIN;
              rd_en_r     <= 1'b0;
              drain_cnt_r <= DRAIN_LAST;
            end else begin
              state_r     <= ST_FETCH;
              rd_en_r     <= 1'b1;
              drain_cnt_r <= {DRAIN_CNT_WIDTH{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (rd_addr_r == last_addr_r) begin
            state_r     <= ST_DRAIN;
            rd_en_r     <= 1'b0;
            drain_cnt_r <= {DRAIN_CNT_WIDTH{1'b0}};
          end else begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= rd_addr_r + PROG_ADDR_WIDTH'(1);
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r       <= ST_DONE;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b1;
            frame_count_r <= frame_count_r + FRAME_CNT_WIDTH'(1);
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_CNT_WIDTH'(1);
          end
        end

        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign prog.prog_rd_en   = rd_en_r;
  assign prog.prog_rd_addr = rd_addr_r;
  assign instruction       = instruction_r;
  assign busy              = busy_r;
  assign frame_done        = frame_done_r;
  assign overrun           = overrun_r;
  assign frame_count       = frame_count_r;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: program RAM model, scoreboard of
// expected instruction words, per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_dsp_sequencer;
  localparam int IW  = 26;
  localparam int AW  = 10;
  localparam int PD  = 5;
  localparam int FCW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run_en = 1'b0;
  logic          sample_strobe = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          overrun_clear = 1'b0;
  logic [IW-1:0] instruction;
  logic          busy, frame_done, overrun;
  logic [FCW-1:0] frame_count;

  dsp_sequencer_if #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW)) prog_bus ();

  dsp_sequencer #(
    .INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .PIPE_DEPTH(PD), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .sample_strobe(sample_strobe),
    .prog_len(prog_len), .prog(prog_bus), .instruction(instruction), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .overrun_clear(overrun_clear),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Program RAM: RAM[i] = 26'h100000 + i, one-cycle read latency.
  logic [IW-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 26'h100000 + 26'(i);
  always @(posedge clk) if (prog_bus.prog_rd_en) prog_bus.prog_rd_data <= mem[prog_bus.prog_rd_addr];

  logic [IW-1:0]  exp_q [$];
  logic [FCW-1:0] fc_exp = '0;
  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs a frame of length len (strobe sampled at E0), optionally a second strobe
  // sampled at E(s2), optionally run_en dropped at E(run_off), checking every cycle.
  task automatic run_frames(input int len, input int s2, input int run_off, input int ncyc, input string tag);
    int eff, done_at, st, j, e_addr;
    bit acc2, e_rd_en, e_win, e_busy, e_done, e_ov;
    logic [IW-1:0] e_instr;
    eff     = (len > 1024) ? 1024 : len;
    done_at = (eff == 0) ? 1 : eff + 1 + PD;
    acc2    = (s2 > 0) && (s2 > done_at);
    @(negedge clk);
    prog_len = 11'(len); run_en = 1'b1; sample_strobe = 1'b1;
    for (int i = 0; i < eff; i++) exp_q.push_back(26'h100000 + 26'(i));
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e_rd_en = 0; e_win = 0; e_busy = 0; e_done = 0; e_addr = 0;
      for (int f = 0; f < 2; f++) begin
        st = (f == 0) ? 0 : (acc2 ? s2 : -100000);
        j  = k - st;
        if (j >= 0 && j < eff) begin e_rd_en = 1; e_addr = j; end
        if (j >= 2 && j < eff + 2) e_win = 1;
        if (j >= 0 && j < done_at) e_busy = 1;
        if (j == done_at) e_done = 1;
      end
      e_ov = (s2 > 0) && !acc2 && (k >= s2);
      if (e_done) fc_exp = fc_exp + 16'd1;

      n_cmp++;
      if (prog_bus.prog_rd_en !== e_rd_en) begin
        n_err++; $display("FAIL %s rd_en k=%0d got %b exp %b", tag, k, prog_bus.prog_rd_en, e_rd_en);
      end
      if (e_rd_en) begin
        n_cmp++;
        if (prog_bus.prog_rd_addr !== 10'(e_addr)) begin
          n_err++; $display("FAIL %s rd_addr k=%0d got %0d exp %0d", tag, k, prog_bus.prog_rd_addr, e_addr);
        end
      end
      if (e_win) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s scoreboard k=%0d empty, got instr %h", tag, k, instruction);
        end else begin
          e_instr = exp_q.pop_front();
          if (instruction !== e_instr) begin
            n_err++; $display("FAIL %s instr k=%0d got %h exp %h", tag, k, instruction, e_instr);
          end
        end
      end else begin
        n_cmp++;
        if (instruction !== 26'd0) begin
          n_err++; $display("FAIL %s nop k=%0d got %h exp 0", tag, k, instruction);
        end
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_err++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, e_busy);
      end
      n_cmp++;
      if (frame_done !== e_done) begin
        n_err++; $display("FAIL %s frame_done k=%0d got %b exp %b", tag, k, frame_done, e_done);
      end
      n_cmp++;
      if (frame_count !== fc_exp) begin
        n_err++; $display("FAIL %s frame_count k=%0d got %0d exp %0d", tag, k, frame_count, fc_exp);
      end
      n_cmp++;
      if (overrun !== e_ov) begin
        n_err++; $display("FAIL %s overrun k=%0d got %b exp %b", tag, k, overrun, e_ov);
      end

      // Drive inputs for edge E(k+1).
      sample_strobe = 1'b0;
      if (s2 > 0 && k == s2 - 1) begin
        sample_strobe = 1'b1;
        prog_len = 11'(len);
        if (acc2) for (int i = 0; i < eff; i++) exp_q.push_back(26'h100000 + 26'(i));
      end else begin
        prog_len = 11'($urandom_range(0, 2047));
      end
      if (run_off > 0 && k == run_off - 1) run_en = 1'b0;
    end
    sample_strobe = 1'b0; run_en = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s leftover words got %0d exp 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({instruction, prog_bus.prog_rd_en, prog_bus.prog_rd_addr, busy, frame_done, overrun, frame_count} !== '0) begin
      n_err++; $display("FAIL reset_held instr=%h en=%b addr=%0d busy=%b done=%b ovr=%b fc=%0d exp all 0",
                        instruction, prog_bus.prog_rd_en, prog_bus.prog_rd_addr, busy, frame_done, overrun, frame_count);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instruction, prog_bus.prog_rd_en, busy, frame_done, overrun, frame_count} !== '0) begin
      n_err++; $display("FAIL reset_idle instr=%h en=%b busy=%b done=%b ovr=%b fc=%0d exp all 0",
                        instruction, prog_bus.prog_rd_en, busy, frame_done, overrun, frame_count);
    end
  endtask

  task automatic test_nominal();    run_frames(4, 0, -1, 14, "nominal");           endtask
  task automatic test_len_zero();   run_frames(0, 0, -1, 5, "len_zero");           endtask
  task automatic test_len_one();    run_frames(1, 0, -1, 10, "len_one");           endtask
  task automatic test_len_clamp();  run_frames(1100, 0, -1, 1034, "len_clamp");    endtask
  task automatic test_back_to_back(); run_frames(4, 11, -1, 25, "back_to_back");   endtask

  task automatic test_overrun();
    int done_cnt;
    run_frames(4, 10, -1, 16, "overrun");
    @(negedge clk); overrun_clear = 1'b1;
    @(negedge clk); overrun_clear = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear got %b exp 0", overrun);
    end
    // Clear coincident with a fresh overrun strobe: set wins.
    @(negedge clk); prog_len = 11'd4; run_en = 1'b1; sample_strobe = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      sample_strobe = 1'b0; overrun_clear = 1'b0;
      if (k == 2) begin sample_strobe = 1'b1; overrun_clear = 1'b1; end
    end
    fc_exp = fc_exp + 16'd1;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set_wins got %b exp 1", overrun);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL overrun_single_frame done pulses got %0d exp 1", done_cnt);
    end
    n_cmp++;
    if (frame_count !== fc_exp) begin
      n_err++; $display("FAIL overrun_frame_count got %0d exp %0d", frame_count, fc_exp);
    end
    @(negedge clk); overrun_clear = 1'b1;
    @(negedge clk); overrun_clear = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear2 got %b exp 0", overrun);
    end
  endtask

  task automatic test_run_en();
    @(negedge clk); run_en = 1'b0; sample_strobe = 1'b1; prog_len = 11'd4;
    @(negedge clk); sample_strobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({busy, prog_bus.prog_rd_en, overrun, frame_done} !== 4'b0000) begin
        n_err++; $display("FAIL run_en_off k=%0d busy=%b en=%b ovr=%b done=%b exp 0",
                          k, busy, prog_bus.prog_rd_en, overrun, frame_done);
      end
      @(negedge clk);
    end
    run_frames(4, 0, 3, 13, "run_en_drop");
  endtask

  task automatic test_async_reset();
    @(negedge clk); prog_len = 11'd4; run_en = 1'b1; sample_strobe = 1'b1;
    @(negedge clk); sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    fc_exp = '0;
    n_cmp++;
    if (instruction !== 26'd0) begin
      n_err++; $display("FAIL async_reset instr got %h exp 0", instruction);
    end
    n_cmp++;
    if ({busy, prog_bus.prog_rd_en, frame_done, overrun} !== 4'b0000 || frame_count !== 16'd0) begin
      n_err++; $display("FAIL async_reset status busy=%b en=%b done=%b ovr=%b fc=%0d exp 0",
                        busy, prog_bus.prog_rd_en, frame_done, overrun, frame_count);
    end
    @(negedge clk);
    n_cmp++;
    if (instruction !== 26'd0 || prog_bus.prog_rd_en !== 1'b0) begin
      n_err++; $display("FAIL async_reset_hold instr=%h en=%b exp 0", instruction, prog_bus.prog_rd_en);
    end
    reset_n = 1'b1;
    run_frames(4, 0, -1, 14, "after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_len_zero();
    test_len_one();
    test_len_clamp();
    test_back_to_back();
    test_overrun();
    test_run_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
